// File: rtl/pattern_window_detector_if.sv
// Serial-bit, configuration and result signals of the pattern window detector.
// The master side drives the bit stream and configuration; the slave side is the detector.
interface pattern_window_detector_if #(
    parameter int PAT_LEN = 3,
    parameter int CNT_W   = 8
);
    logic               in_valid;
    logic               in_bit;
    logic               cfg_load;
    logic [PAT_LEN-1:0] cfg_pattern;
    logic               cfg_overlap;
    logic               hit;
    logic               match;
    logic [CNT_W-1:0]   hit_count;

    modport master (
        output in_valid, in_bit, cfg_load, cfg_pattern, cfg_overlap,
        input  hit, match, hit_count
    );

    modport slave (
        input  in_valid, in_bit, cfg_load, cfg_pattern, cfg_overlap,
        output hit, match, hit_count
    );
endinterface

// File: rtl/pattern_window_detector.sv
// Serial pattern detector: counts PAT_LEN-bit pattern hits and flags whether the
// latest hit still lies inside the last WINDOW accepted bits.
module pattern_window_detector #(
    parameter int PAT_LEN = 3,
    parameter int WINDOW  = 4,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic rst_n,
    pattern_window_detector_if.slave bus
);
    localparam int FILL_W = $clog2(PAT_LEN + 1);
    localparam int AGE_W  = $clog2(WINDOW + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
    localparam logic [AGE_W-1:0]  AGE_MAX   = AGE_W'(WINDOW);
    localparam logic [AGE_W-1:0]  AGE_LIMIT = AGE_W'(WINDOW - PAT_LEN);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    // Power-up pattern alternates and ends in 1 (101 for three bits).
    function automatic logic [PAT_LEN-1:0] alt_pattern();
        logic [PAT_LEN-1:0] p;
        for (int i = 0; i < PAT_LEN; i++) begin
            p[i] = ((i % 2) == 0) ? 1'b1 : 1'b0;
        end
        return p;
    endfunction

    localparam logic [PAT_LEN-1:0] RST_PATTERN = alt_pattern();

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_ARMED = 2'd1,
        ST_HIT   = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    logic               run_q;
    logic [PAT_LEN-1:0] pattern_q, pattern_d;
    logic               overlap_q, overlap_d;
    logic [PAT_LEN-1:0] hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [AGE_W-1:0]   age_q, age_d;
    logic               seen_q, seen_d;
    state_e             state_q, state_d;
    logic               hit_q, hit_d;
    logic               match_q, match_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               load;
    logic               accept;
    logic [PAT_LEN-1:0] hist_shift;
    logic [FILL_W-1:0]  fill_inc;
    logic [AGE_W-1:0]   age_inc;
    logic               hit_now;

    // run_q opens one edge after reset release, so the first bit lands on the second edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    assign load       = run_q & bus.cfg_load;
    assign accept     = run_q & bus.in_valid & ~bus.cfg_load;
    assign hist_shift = {hist_q[PAT_LEN-2:0], bus.in_bit};
    assign fill_inc   = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);
    assign age_inc    = (age_q == AGE_MAX) ? AGE_MAX : age_q + AGE_W'(1);
    assign hit_now    = accept && (fill_inc == FILL_FULL) && (hist_shift == pattern_q);

    always_comb begin
        pattern_d = pattern_q;
        overlap_d = overlap_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        age_d     = age_q;
        seen_d    = seen_q;
        state_d   = state_q;
        count_d   = count_q;
        hit_d     = 1'b0;
        match_d   = match_q;

        if (load) begin
            pattern_d = bus.cfg_pattern;
            overlap_d = bus.cfg_overlap;
            hist_d    = '0;
            fill_d    = '0;
            age_d     = '0;
            seen_d    = 1'b0;
            count_d   = '0;
            state_d   = ST_FILL;
        end else if (accept) begin
            hist_d = hist_shift;
            if (hit_now) begin
                // Non-overlap mode makes the next hit wait for PAT_LEN fresh bits.
                fill_d  = overlap_q ? fill_inc : '0;
                age_d   = '0;
                seen_d  = 1'b1;
                hit_d   = 1'b1;
                count_d = (count_q == CNT_MAX) ? CNT_MAX : count_q + CNT_W'(1);
                state_d = ST_HIT;
            end else begin
                fill_d = fill_inc;
                age_d  = age_inc;
                if (seen_q && (age_inc <= AGE_LIMIT)) begin
                    state_d = ST_HOLD;
                end else if (fill_inc != FILL_FULL) begin
                    state_d = ST_FILL;
                end else begin
                    state_d = ST_ARMED;
                end
            end
        end

        // match follows the state: asserted only while the last hit is still in the window.
        if (load || accept) begin
            match_d = (state_d == ST_HIT) || (state_d == ST_HOLD);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_q <= RST_PATTERN;
            overlap_q <= 1'b1;
            hist_q    <= '0;
            fill_q    <= '0;
            age_q     <= '0;
            seen_q    <= 1'b0;
            state_q   <= ST_FILL;
            count_q   <= '0;
            hit_q     <= 1'b0;
            match_q   <= 1'b0;
        end else begin
            pattern_q <= pattern_d;
            overlap_q <= overlap_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            age_q     <= age_d;
            seen_q    <= seen_d;
            state_q   <= state_d;
            count_q   <= count_d;
            hit_q     <= hit_d;
            match_q   <= match_d;
        end
    end

    assign bus.hit       = hit_q;
    assign bus.match     = match_q;
    assign bus.hit_count = count_q;

endmodule

// File: tb/tb_pattern_window_detector.sv
// Directed bench for pattern_window_detector: default instance plus a CNT_W=2 instance
// for counter saturation; expected values are hand-derived bit sequences.
module tb_pattern_window_detector;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    pattern_window_detector_if #(.PAT_LEN(3), .CNT_W(8)) bus ();
    pattern_window_detector_if #(.PAT_LEN(3), .CNT_W(2)) bus2 ();

    pattern_window_detector #(.PAT_LEN(3), .WINDOW(4), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    pattern_window_detector #(.PAT_LEN(3), .WINDOW(4), .CNT_W(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send(input logic b);
        bus.in_valid = 1'b1;
        bus.in_bit   = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send2(input logic b);
        bus2.in_valid = 1'b1;
        bus2.in_bit   = b;
        @(posedge clk);
        #1;
        bus2.in_valid = 1'b0;
    endtask

    task automatic load(input logic [2:0] pat, input logic ovl);
        bus.cfg_load    = 1'b1;
        bus.cfg_pattern = pat;
        bus.cfg_overlap = ovl;
        @(posedge clk);
        #1;
        bus.cfg_load = 1'b0;
    endtask

    task automatic test_reset();
        logic [2:0] bits_a;
        logic [3:0] bits_b;
        logic [3:0] hits_b;
        bits_a = 3'b101;
        bits_b = 4'b1101;
        hits_b = 4'b0001;
        #3 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.hit !== 1'b0 || bus.match !== 1'b0 || bus.hit_count !== 8'd0) begin
            n_err++;
            $display("FAIL reset_state: hit=%b match=%b count=%0d, expected 0 0 0",
                     bus.hit, bus.match, bus.hit_count);
        end
        // Edge 1 after release must be ignored: 1,0,1 offered yields only two accepted bits.
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(bits_a[2-i]);
            n_cmp++;
            if (bus.hit !== 1'b0) begin
                n_err++;
                $display("FAIL reset_first_edge bit%0d: hit=%b, expected 0", i, bus.hit);
            end
        end
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        // Edge 2 after release must be accepted: 1,1,0,1 hits on the last bit.
        for (int i = 0; i < 4; i++) begin
            send(bits_b[3-i]);
            n_cmp++;
            if (bus.hit !== hits_b[3-i]) begin
                n_err++;
                $display("FAIL reset_second_edge bit%0d: hit=%b, expected %b",
                         i, bus.hit, hits_b[3-i]);
            end
        end
        n_cmp++;
        if (bus.hit_count !== 8'd1) begin
            n_err++;
            $display("FAIL reset_second_edge count: got %0d, expected 1", bus.hit_count);
        end
    endtask

    task automatic test_overlap();
        logic [12:0] bits_v;
        logic [12:0] match_v;
        logic [12:0] hit_v;
        bits_v  = 13'b0101001101010;
        match_v = 13'b0001100001111;
        hit_v   = 13'b0001000001010;
        load(3'b101, 1'b1);
        n_cmp++;
        if (bus.hit !== 1'b0 || bus.match !== 1'b0 || bus.hit_count !== 8'd0) begin
            n_err++;
            $display("FAIL overlap_load_clear: hit=%b match=%b count=%0d, expected 0 0 0",
                     bus.hit, bus.match, bus.hit_count);
        end
        for (int i = 0; i < 13; i++) begin
            send(bits_v[12-i]);
            n_cmp++;
            if (bus.match !== match_v[12-i]) begin
                n_err++;
                $display("FAIL overlap_match bit%0d: got %b, expected %b", i + 1, bus.match, match_v[12-i]);
            end
            n_cmp++;
            if (bus.hit !== hit_v[12-i]) begin
                n_err++;
                $display("FAIL overlap_hit bit%0d: got %b, expected %b", i + 1, bus.hit, hit_v[12-i]);
            end
        end
        n_cmp++;
        if (bus.hit_count !== 8'd3) begin
            n_err++;
            $display("FAIL overlap_count: got %0d, expected 3", bus.hit_count);
        end
    endtask

    task automatic test_nonoverlap();
        logic [4:0] bits_v;
        logic [4:0] hit_v;
        logic [4:0] match_v;
        bits_v  = 5'b10101;
        hit_v   = 5'b00100;
        match_v = 5'b00110;
        load(3'b101, 1'b0);
        for (int i = 0; i < 5; i++) begin
            send(bits_v[4-i]);
            n_cmp++;
            if (bus.hit !== hit_v[4-i]) begin
                n_err++;
                $display("FAIL nonoverlap_hit bit%0d: got %b, expected %b", i + 1, bus.hit, hit_v[4-i]);
            end
            n_cmp++;
            if (bus.match !== match_v[4-i]) begin
                n_err++;
                $display("FAIL nonoverlap_match bit%0d: got %b, expected %b", i + 1, bus.match, match_v[4-i]);
            end
        end
        n_cmp++;
        if (bus.hit_count !== 8'd1) begin
            n_err++;
            $display("FAIL nonoverlap_count: got %0d, expected 1", bus.hit_count);
        end
    endtask

    task automatic test_cfg_midstream();
        logic [2:0] hit_v;
        hit_v = 3'b001;
        load(3'b101, 1'b1);
        send(1'b1);
        send(1'b0);
        send(1'b1);
        n_cmp++;
        if (bus.match !== 1'b1) begin
            n_err++;
            $display("FAIL cfg_pre_match: got %b, expected 1", bus.match);
        end
        load(3'b110, 1'b1);
        n_cmp++;
        if (bus.match !== 1'b0 || bus.hit !== 1'b0 || bus.hit_count !== 8'd0) begin
            n_err++;
            $display("FAIL cfg_clear: match=%b hit=%b count=%0d, expected 0 0 0",
                     bus.match, bus.hit, bus.hit_count);
        end
        send(1'b1);
        send(1'b1);
        send(1'b0);
        n_cmp++;
        if (bus.hit !== hit_v[0]) begin
            n_err++;
            $display("FAIL cfg_new_hit: got %b, expected 1", bus.hit);
        end
        n_cmp++;
        if (bus.hit_count !== 8'd1) begin
            n_err++;
            $display("FAIL cfg_new_count: got %0d, expected 1", bus.hit_count);
        end
    endtask

    task automatic test_gaps();
        logic [12:0] bits_v;
        logic [12:0] match_v;
        logic [12:0] hit_v;
        bits_v  = 13'b0101001101010;
        match_v = 13'b0001100001111;
        hit_v   = 13'b0001000001010;
        load(3'b101, 1'b1);
        for (int i = 0; i < 13; i++) begin
            send(bits_v[12-i]);
            n_cmp++;
            if (bus.hit !== hit_v[12-i] || bus.match !== match_v[12-i]) begin
                n_err++;
                $display("FAIL gap_bit%0d: hit=%b match=%b, expected %b %b",
                         i + 1, bus.hit, bus.match, hit_v[12-i], match_v[12-i]);
            end
            for (int g = 0; g < (i % 3); g++) begin
                @(posedge clk);
                #1;
                n_cmp++;
                if (bus.hit !== 1'b0 || bus.match !== match_v[12-i]) begin
                    n_err++;
                    $display("FAIL gap_idle bit%0d gap%0d: hit=%b match=%b, expected 0 %b",
                             i + 1, g, bus.hit, bus.match, match_v[12-i]);
                end
            end
        end
        n_cmp++;
        if (bus.hit_count !== 8'd3) begin
            n_err++;
            $display("FAIL gap_count: got %0d, expected 3", bus.hit_count);
        end
    endtask

    task automatic test_async_reset_collision();
        load(3'b101, 1'b1);
        send(1'b1);
        send(1'b0);
        send(1'b1);
        n_cmp++;
        if (bus.match !== 1'b1 || bus.hit !== 1'b1) begin
            n_err++;
            $display("FAIL async_pre: match=%b hit=%b, expected 1 1", bus.match, bus.hit);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.match !== 1'b0 || bus.hit !== 1'b0 || bus.hit_count !== 8'd0) begin
            n_err++;
            $display("FAIL async_reset: match=%b hit=%b count=%0d, expected 0 0 0",
                     bus.match, bus.hit, bus.hit_count);
        end
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        // cfg_load and a valid '1' collide: the '1' must be dropped.
        bus.in_valid = 1'b1;
        bus.in_bit   = 1'b1;
        load(3'b101, 1'b1);
        bus.in_valid = 1'b0;
        send(1'b0);
        send(1'b1);
        n_cmp++;
        if (bus.hit !== 1'b0 || bus.hit_count !== 8'd0) begin
            n_err++;
            $display("FAIL collision_discard: hit=%b count=%0d, expected 0 0", bus.hit, bus.hit_count);
        end
        send(1'b0);
        send(1'b1);
        n_cmp++;
        if (bus.hit !== 1'b1 || bus.hit_count !== 8'd1) begin
            n_err++;
            $display("FAIL collision_after: hit=%b count=%0d, expected 1 1", bus.hit, bus.hit_count);
        end
    endtask

    task automatic test_saturate();
        int exp_hits;
        logic exp_hit;
        logic [1:0] exp_cnt;
        exp_hits = 0;
        for (int i = 0; i < 11; i++) begin
            send2((i % 2) == 0 ? 1'b1 : 1'b0);
            exp_hit  = (i >= 2) && ((i % 2) == 0);
            exp_hits = exp_hits + (exp_hit ? 1 : 0);
            exp_cnt  = (exp_hits > 3) ? 2'd3 : 2'(exp_hits);
            n_cmp++;
            if (bus2.hit !== exp_hit || bus2.hit_count !== exp_cnt) begin
                n_err++;
                $display("FAIL saturate bit%0d: hit=%b count=%0d, expected %b %0d",
                         i + 1, bus2.hit, bus2.hit_count, exp_hit, exp_cnt);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b1;
        bus.in_valid     = 1'b0;
        bus.in_bit       = 1'b0;
        bus.cfg_load     = 1'b0;
        bus.cfg_pattern  = 3'b000;
        bus.cfg_overlap  = 1'b0;
        bus2.in_valid    = 1'b0;
        bus2.in_bit      = 1'b0;
        bus2.cfg_load    = 1'b0;
        bus2.cfg_pattern = 3'b000;
        bus2.cfg_overlap = 1'b0;

        test_reset();
        test_overlap();
        test_nonoverlap();
        test_cfg_midstream();
        test_gaps();
        test_async_reset_collision();
        test_saturate();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pattern_window_detector.md
PATTERN_WINDOW_DETECTOR -- requirements
Module: pattern_window_detector

Interface
REQ-001 The block SHALL have parameter PAT_LEN, default 3, meaning the pattern length in bits (legal range 2..16).
REQ-002 The block SHALL have parameter WINDOW, default 4, meaning the number of most-recent accepted bits searched (legal range PAT_LEN..32).
REQ-003 The block SHALL have parameter CNT_W, default 8, meaning the width of the hit counter.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit, reset that is asynchronous and active-low.
REQ-006 The block SHALL have port in_valid, input, 1 bit, which qualifies in_bit; a bit is accepted only on a rising edge with in_valid=1.
REQ-007 The block SHALL have port in_bit, input, 1 bit, the serial data bit.
REQ-008 The block SHALL have port cfg_load, input, 1 bit, a one-cycle strobe that loads cfg_pattern and cfg_overlap.
REQ-009 The block SHALL have port cfg_pattern, input, PAT_LEN bits; bit PAT_LEN-1 is the oldest (first-received) pattern bit.
REQ-010 The block SHALL have port cfg_overlap, input, 1 bit: 1 selects overlapping search, 0 selects non-overlapping search.
REQ-011 The block SHALL have port hit, output, 1 bit, a one-cycle pulse registered on the edge after the accepted bit that completes a pattern.
REQ-012 The block SHALL have port match, output, 1 bit, registered, high while the most recent hit lies fully within the last WINDOW accepted bits.
REQ-013 The block SHALL have port hit_count, output, CNT_W bits, the saturating count of hits since reset or the last cfg_load.

Function
REQ-014 The block SHALL keep a history of the last PAT_LEN accepted bits and a fill counter of accepted bits, 0..PAT_LEN, saturating.
REQ-015 A hit SHALL occur on an accepted bit when the fill counter, including that bit, reaches PAT_LEN and the history equals the loaded pattern.
REQ-016 In overlap mode the fill counter SHALL be left unchanged by a hit, so bits of one hit can start the next hit (10101 with pattern 101 gives 2 hits).
REQ-017 In non-overlap mode a hit SHALL reset the fill counter to 0, so the next hit needs PAT_LEN fresh bits (10101 with pattern 101 gives 1 hit).
REQ-018 The block SHALL keep a hit-age counter of accepted bits since the last hit end, set to 0 on a hit, incremented per accepted bit and saturating at WINDOW.
REQ-019 match SHALL be 1 iff a hit has occurred since reset/cfg_load and hit-age <= WINDOW-PAT_LEN; it SHALL be updated on the same edge as hit.
REQ-020 Latency from the edge accepting the completing bit to hit=1 and match=1 SHALL be 1 cycle; with in_valid=0, state and match SHALL hold and hit SHALL be 0.
REQ-021 hit_count SHALL increment by 1 per hit and hold at 2^CNT_W-1 with no wrap.
REQ-022 cfg_load SHALL latch cfg_pattern and cfg_overlap, and clear history, fill counter, hit-age, the hit-seen flag and hit_count; match and hit SHALL read 0 on the next cycle.
REQ-023 If cfg_load and in_valid are both high on the same edge, cfg_load SHALL win and the in_bit SHALL be discarded.
REQ-024 The state SHALL be a four-state machine: FILL (fill<PAT_LEN), ARMED (full, no recent hit), HIT (hit this bit) and HOLD (match asserted, no new hit).
REQ-025 State transitions: FILL->ARMED at full; ARMED/HOLD->HIT on a hit; HIT->HOLD on a non-hit accepted bit; HOLD->ARMED when hit-age exceeds WINDOW-PAT_LEN; HIT->FILL on a non-overlap hit.

Reset
REQ-026 rst_n=0 SHALL immediately, without a clock, clear hit, match, hit_count, history, fill, hit-age and state (FILL), and load the pattern register with 3'b101 for the default PAT_LEN, generally with the alternating pattern ending in 1.
REQ-027 Overlap mode SHALL reset to 1; deassertion of rst_n SHALL be synchronised so that the first bit is accepted on the second rising edge after release.

Verification
REQ-028 Default params and pattern 101, overlap: accept 0 1 0 1 0 0 1 1 0 1 0 1 0 -> match one cycle later = 0 0 0 1 1 0 0 0 0 1 1 1 1; hit pulses after bits 4, 10, 12; hit_count=3.
REQ-029 Non-overlap, pattern 101: accept 1 0 1 0 1 -> one hit after bit 3 and none after bit 5; hit_count=1.
REQ-030 cfg_load pattern 110 mid-stream, then accept 1 1 0 -> previous match cleared, hit after bit 3, hit_count=1.
REQ-031 in_valid=0 gaps inserted between pattern bits -> same hit/match sequence as gap-free, and outputs hold during gaps.
REQ-032 rst_n pulsed low between clock edges while match=1 -> match, hit, hit_count go 0 immediately; a cfg_load+in_valid collision discards the bit.
REQ-033 CNT_W=2 with 5 hits -> hit_count saturates at 3.
